// File: rtl/frame_timer_mc.sv
// Multi-channel Avalon-MM interval timer: per-channel down-counters with one-shot or
// continuous reload, global start, counter snapshot, interrupt and stretched timeout pulse.
module frame_timer_mc #(
   parameter int          CHANNELS    = 2,
   parameter int          CNT_W       = 32,
   parameter int unsigned PERIOD_INIT = 4999,
   parameter int          PULSE_W     = 1,
   localparam int         ADDR_W      = $clog2(CHANNELS) + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [CHANNELS-1:0] timeout_pulse
);

   localparam int CH_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;
   localparam int CH_W1 = CH_W + 1;
   localparam int PC_W  = $clog2(PULSE_W + 1);
   localparam logic [CH_W:0] CH_LIM = CH_W1'(CHANNELS);

   logic [CH_W-1:0] ch_sel;
   logic [1:0]      reg_sel;
   logic            wr_en;
   logic            ch_valid;
   logic            gstart_all;
   logic [31:0]     rd_next;

   logic [CNT_W-1:0]    count_a  [CHANNELS];
   logic [CNT_W-1:0]    period_a [CHANNELS];
   logic [CNT_W-1:0]    snap_a   [CHANNELS];
   logic [CHANNELS-1:0] run_v, to_v, cont_v, ito_v;

   if (ADDR_W > 2) begin : g_chsel
      assign ch_sel = address[ADDR_W-1:2];
   end else begin : g_chsel_single
      assign ch_sel = '0;
   end

   assign reg_sel  = address[1:0];
   assign wr_en    = chipselect && !write_n;
   assign ch_valid = {1'b0, ch_sel} < CH_LIM;
   // A CONTROL write carrying both GSTART and START starts every channel at once.
   assign gstart_all = wr_en && ch_valid && (reg_sel == 2'd1) && writedata[4] && writedata[2];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [CNT_W-1:0] count_q, period_q, snap_q;
      logic             run_q, to_q, cont_q, ito_q, reload_q;
      logic [PC_W-1:0]  pcnt_q;
      logic             hit, tc, start_s, stop_s;

      assign hit     = wr_en && (ch_sel == CH_W'(i));
      assign tc      = run_q && (count_q == '0);
      assign start_s = (hit && (reg_sel == 2'd1) && writedata[2]) || gstart_all;
      assign stop_s  = hit && (reg_sel == 2'd1) && writedata[3];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            count_q  <= CNT_W'(PERIOD_INIT);
            period_q <= CNT_W'(PERIOD_INIT);
            snap_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            reload_q <= 1'b0;
            pcnt_q   <= '0;
         end else begin
            reload_q <= hit && (reg_sel == 2'd2);
            if (hit && (reg_sel == 2'd2)) period_q <= writedata[CNT_W-1:0];
            if (hit && (reg_sel == 2'd1)) begin
               cont_q <= writedata[1];
               ito_q  <= writedata[0];
            end
            if (hit && (reg_sel == 2'd3)) snap_q <= count_q;

            // A STATUS write in the same cycle as a terminal count leaves TO clear.
            if (hit && (reg_sel == 2'd0)) to_q <= 1'b0;
            else if (tc)                  to_q <= 1'b1;

            if (start_s)          run_q <= 1'b1;
            else if (stop_s)      run_q <= 1'b0;
            else if (reload_q)    run_q <= 1'b0;
            else if (tc && !cont_q) run_q <= 1'b0;

            if (reload_q || tc) count_q <= period_q;
            else if (run_q)     count_q <= count_q - CNT_W'(1);

            if (tc)                  pcnt_q <= PC_W'(PULSE_W);
            else if (pcnt_q != '0)   pcnt_q <= pcnt_q - PC_W'(1);
         end
      end

      assign count_a[i]       = count_q;
      assign period_a[i]      = period_q;
      assign snap_a[i]        = snap_q;
      assign run_v[i]         = run_q;
      assign to_v[i]          = to_q;
      assign cont_v[i]        = cont_q;
      assign ito_v[i]         = ito_q;
      assign timeout_pulse[i] = (pcnt_q != '0);
   end

   assign irq = |(to_v & ito_v);

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_sel == CH_W'(i)) begin
            case (reg_sel)
               2'd0:    rd_next = {30'b0, run_v[i], to_v[i]};
               2'd1:    rd_next = {30'b0, cont_v[i], ito_v[i]};
               2'd2:    rd_next = 32'(period_a[i]);
               default: rd_next = 32'(snap_a[i]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   // count_a is read only through SNAPSHOT capture inside each channel.
   logic unused_count;
   assign unused_count = ^count_a[0];

endmodule

// File: tb/tb_frame_timer_mc.sv
// Directed bench for frame_timer_mc: a 2-channel 32-bit instance and a 3-channel
// 16-bit instance with PULSE_W=3 sharing address/write bus with separate chip selects.
module tb_frame_timer_mc;

   logic        clk, reset_n, chipselect, cs3, write_n;
   logic [3:0]  address;
   logic [31:0] writedata, readdata, readdata3;
   logic        irq, irq3;
   logic [1:0]  tp;
   logic [2:0]  tp3;

   logic [31:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   frame_timer_mc #(.CHANNELS(2), .CNT_W(32), .PERIOD_INIT(4999), .PULSE_W(1)) dut (
      .clk(clk), .reset_n(reset_n), .address(address[2:0]), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .timeout_pulse(tp)
   );

   frame_timer_mc #(.CHANNELS(3), .CNT_W(16), .PERIOD_INIT(4999), .PULSE_W(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs3),
      .write_n(write_n), .writedata(writedata), .readdata(readdata3), .irq(irq3),
      .timeout_pulse(tp3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
      end
   endtask

   task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      write_n    = 1'b0;
      chipselect = (sel == 0);
      cs3        = (sel == 1);
      @(negedge clk);
      write_n    = 1'b1;
      chipselect = 1'b0;
      cs3        = 1'b0;
   endtask

   task automatic rd(input string tag, input int sel, input logic [3:0] a, input logic [31:0] e);
      logic [31:0] obs, ex;
      address = a;
      exp_q.push_back(e);
      @(negedge clk);
      obs = (sel == 0) ? readdata : readdata3;
      ex  = exp_q.pop_front();
      chk(tag, obs, ex);
   endtask

   // Observed word per cycle: {irq, timeout_pulse} of the selected instance.
   task automatic cyc_chk(input string tag, input int sel, input logic [31:0] e);
      logic [31:0] obs, ex;
      exp_q.push_back(e);
      @(negedge clk);
      obs = (sel == 0) ? {29'b0, irq, tp} : {28'b0, irq3, tp3};
      ex  = exp_q.pop_front();
      chk(tag, obs, ex);
   endtask

   initial begin
      logic [31:0] e;
      reset_n = 1'b0; chipselect = 1'b0; cs3 = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0;
      repeat (3) @(negedge clk);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_pulse", {30'b0, tp}, 32'd0);
      chk("rst_pulse3", {29'b0, tp3}, 32'd0);
      reset_n = 1'b1;
      rd("rst_period0", 0, 4'd2, 32'd4999);
      rd("rst_status0", 0, 4'd0, 32'd0);
      rd("rst_snap0", 0, 4'd3, 32'd0);
      rd("rst_ctrl1", 0, 4'd5, 32'd0);

      // ch0 continuous, period 10 cycles, interrupt enabled
      wr(0, 4'd2, 32'd9);
      wr(0, 4'd1, 32'h3);
      wr(0, 4'd1, 32'h7);
      for (int j = 1; j <= 25; j++) begin
         e = '0; e[2] = (j >= 10); e[0] = (j % 10 == 0);
         cyc_chk("cont_ch0", 0, e);
      end
      wr(0, 4'd0, 32'd0);
      chk("status_clr_irq", {31'b0, irq}, 32'd0);
      repeat (3) @(negedge clk);
      wr(0, 4'd0, 32'd0);
      chk("clr_vs_tc", {29'b0, irq, tp}, 32'h1);
      rd("clr_vs_tc_status", 0, 4'd0, 32'h2);
      wr(0, 4'd1, 32'h8);

      // ch1 one-shot; START coincides with the PERIOD-write reload
      wr(0, 4'd6, 32'd4);
      wr(0, 4'd5, 32'h5);
      for (int j = 1; j <= 15; j++) begin
         e = '0; e[2] = (j >= 5); e[1] = (j == 5);
         cyc_chk("oneshot_ch1", 0, e);
      end
      rd("oneshot_status", 0, 4'd4, 32'h1);
      wr(0, 4'd7, 32'd0);
      rd("oneshot_snap", 0, 4'd7, 32'd4);
      rd("ctrl_strobes_rd0", 0, 4'd5, 32'h1);
      wr(0, 4'd1, 32'hC);
      rd("start_beats_stop", 0, 4'd0, 32'h2);

      // PULSE_W=3 stretching on the 3-channel instance
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      rd("rst3_period0", 1, 4'd2, 32'd4999);
      wr(1, 4'd2, 32'd1);
      wr(1, 4'd1, 32'h6);
      for (int m = 1; m <= 12; m++) begin
         e = '0; e[0] = (m >= 2);
         cyc_chk("stretch_p1", 1, e);
      end
      wr(1, 4'd2, 32'd5);
      wr(1, 4'd1, 32'h6);
      repeat (2) @(negedge clk);
      for (int m = 3; m <= 20; m++) begin
         e = '0; e[0] = (m >= 6) && ((m - 6) % 6 < 3);
         cyc_chk("stretch_p5", 1, e);
      end

      // channel index 3 does not exist on the 3-channel instance
      wr(1, 4'd14, 32'h55);
      wr(1, 4'd13, 32'h17);
      rd("bad_ch_period", 1, 4'd14, 32'd0);
      rd("bad_ch_ctrl", 1, 4'd13, 32'd0);
      rd("bad_ch_status", 1, 4'd12, 32'd0);
      rd("ch2_period_kept", 1, 4'd10, 32'd4999);
      rd("ch2_not_started", 1, 4'd8, 32'd0);
      rd("ch1_not_started", 1, 4'd4, 32'd0);
      rd("ch0_period_kept", 1, 4'd2, 32'd5);
      chk("bad_ch_irq", {31'b0, irq3}, 32'd0);
      wr(1, 4'd6, 32'hABCD1234);
      rd("period_zero_ext", 1, 4'd6, 32'h1234);

      // global start keeps equal channels aligned
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wr(0, 4'd2, 32'd7);
      wr(0, 4'd6, 32'd7);
      wr(0, 4'd1, 32'h2);
      wr(0, 4'd5, 32'h17);
      for (int j = 1; j <= 24; j++) begin
         e = '0; e[2] = (j >= 8); e[1] = (j % 8 == 0); e[0] = (j % 8 == 0);
         cyc_chk("gstart_align", 0, e);
      end
      wr(0, 4'd2, 32'd3);
      for (int j = 26; j <= 41; j++) begin
         e = '0; e[2] = 1'b1; e[1] = (j % 8 == 0);
         cyc_chk("period_wr_stops_ch0", 0, e);
      end
      rd("ch0_stopped", 0, 4'd0, 32'h1);
      rd("ch1_running", 0, 4'd4, 32'h3);
      @(negedge clk);
      chk("pre_reset_rd", readdata, 32'h3);
      chk("pre_reset_irq", {31'b0, irq}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_rd", readdata, 32'd0);
      chk("async_rst_irq", {31'b0, irq}, 32'd0);
      chk("async_rst_pulse", {30'b0, tp}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
